// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the operand muxes, the ALU execute stage and writeback.
interface alu_exec_unit_if #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned DEST_W    = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           op;
    logic [WORD_SIZE-1:0] operand_a;
    logic [WORD_SIZE-1:0] operand_b;
    logic [DEST_W-1:0]    dest_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] result;
    logic [DEST_W-1:0]    out_dest;
    logic [3:0]           flags;
    logic                 busy;

    // Issue/writeback side: drives operations in and consumes results.
    modport master (
        output in_valid, op, operand_a, operand_b, dest_sel, out_ready,
        input  in_ready, out_valid, result, out_dest, flags, busy
    );

    // Execute unit side.
    modport slave (
        input  in_valid, op, operand_a, operand_b, dest_sel, out_ready,
        output in_ready, out_valid, result, out_dest, flags, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Sequential ALU execute stage: single-cycle ALU ops, iterative MUL/DIV/MOD,
// valid/ready handshake on both sides, persistent {V,N,C,Z} flags.
module alu_exec_unit #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned DEST_W    = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus
);
    localparam int unsigned WP1   = WORD_SIZE + 1;
    localparam int unsigned MSB   = WORD_SIZE - 1;
    localparam int unsigned CNT_W = $clog2(WORD_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_SIZE - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_MOD  = 4'd11;
    localparam logic [3:0] OP_PASS = 4'd12;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           op_q;
    logic [WORD_SIZE-1:0] acc;
    logic [WORD_SIZE-1:0] qr;
    logic [WORD_SIZE-1:0] b_q;
    logic [DEST_W-1:0]    dest_q;
    logic [WORD_SIZE-1:0] result_q;
    logic [DEST_W-1:0]    out_dest_q;
    logic [3:0]           flags_q;
    logic                 in_ready;
    logic                 accept;

    logic [WORD_SIZE-1:0] a;
    logic [WORD_SIZE-1:0] b;
    logic                 cin;
    logic [WP1-1:0]       add_full;
    logic [WP1-1:0]       sub_full;
    logic [WORD_SIZE-1:0] sc_result;
    logic                 sc_c;
    logic                 sc_v;
    logic                 sc_upd;
    logic                 sc_iter;
    logic [3:0]           sc_flags;

    logic [WP1-1:0]       mul_sum;
    logic [WP1-1:0]       div_shift;
    logic [WORD_SIZE-1:0] div_diff;
    logic                 div_ge;
    logic [WORD_SIZE-1:0] acc_nx;
    logic [WORD_SIZE-1:0] qr_nx;
    logic [WORD_SIZE-1:0] it_result;
    logic                 it_c;
    logic [3:0]           it_flags;

    // Handshake and status decode from the state register.
    assign in_ready      = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = result_q;
    assign bus.out_dest  = out_dest_q;
    assign bus.flags     = flags_q;

    // Single-cycle ops and divide-by-zero, evaluated on the incoming operands.
    always_comb begin
        a         = bus.operand_a;
        b         = bus.operand_b;
        cin       = (bus.op == OP_ADC) ? flags_q[1] : 1'b0;
        add_full  = {1'b0, a} + {1'b0, b} + WP1'(cin);
        sub_full  = {1'b0, a} - {1'b0, b};
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        sc_upd    = 1'b1;
        sc_iter   = 1'b0;
        case (bus.op)
            OP_ADD, OP_ADC: begin
                sc_result = add_full[MSB:0];
                sc_c      = add_full[WORD_SIZE];
                sc_v      = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sc_result = sub_full[MSB:0];
                sc_c      = sub_full[WORD_SIZE];
                sc_v      = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
            end
            OP_AND:  sc_result = a & b;
            OP_OR:   sc_result = a | b;
            OP_XOR:  sc_result = a ^ b;
            OP_NOT:  sc_result = ~a;
            OP_SHL: begin
                sc_result = {a[MSB-1:0], 1'b0};
                sc_c      = a[MSB];
            end
            OP_SHR: begin
                sc_result = {1'b0, a[MSB:1]};
                sc_c      = a[0];
            end
            OP_PASS: sc_result = b;
            OP_MUL:  sc_iter = 1'b1;
            OP_DIV, OP_MOD: begin
                if (b == '0) begin
                    sc_result = '1;
                    sc_v      = 1'b1;
                end else begin
                    sc_iter = 1'b1;
                end
            end
            default: sc_upd = 1'b0;
        endcase
        sc_flags = {sc_v, sc_result[MSB], sc_c, (sc_result == '0)};
    end

    // One shift-add (MUL) or restoring-divide step on the acc/qr pair.
    always_comb begin
        mul_sum   = {1'b0, acc} + (qr[0] ? {1'b0, b_q} : WP1'(0));
        div_shift = {acc, qr[MSB]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift[MSB:0] - b_q;
        if (op_q == OP_MUL) begin
            acc_nx = mul_sum[WORD_SIZE:1];
            qr_nx  = {mul_sum[0], qr[MSB:1]};
        end else begin
            acc_nx = div_ge ? div_diff : div_shift[MSB:0];
            qr_nx  = {qr[MSB-1:0], div_ge};
        end
        it_result = (op_q == OP_MOD) ? acc_nx : qr_nx;
        it_c      = (op_q == OP_MUL) && (acc_nx != '0);
        it_flags  = {1'b0, it_result[MSB], it_c, (it_result == '0)};
    end

    // Control FSM plus operand, iteration and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= OP_ADD;
            acc        <= '0;
            qr         <= '0;
            b_q        <= '0;
            dest_q     <= '0;
            result_q   <= '0;
            out_dest_q <= '0;
            flags_q    <= '0;
        end else begin
            case (state)
                CALC: begin
                    acc <= acc_nx;
                    qr  <= qr_nx;
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        state      <= DONE;
                        result_q   <= it_result;
                        flags_q    <= it_flags;
                        out_dest_q <= dest_q;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: ;
            endcase
            // Accept overrides the DONE->IDLE drop for back-to-back issue.
            if (accept) begin
                op_q   <= bus.op;
                b_q    <= bus.operand_b;
                dest_q <= bus.dest_sel;
                cnt    <= '0;
                if (sc_iter) begin
                    state <= CALC;
                    acc   <= '0;
                    qr    <= bus.operand_a;
                end else begin
                    state      <= DONE;
                    result_q   <= sc_result;
                    out_dest_q <= bus.dest_sel;
                    if (sc_upd) begin
                        flags_q <= sc_flags;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
    localparam int unsigned W  = 8;
    localparam int unsigned DW = 3;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [3:0] mflags;

    alu_exec_unit_if #(.WORD_SIZE(W), .DEST_W(DW)) bus ();

    alu_exec_unit #(.WORD_SIZE(W), .DEST_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vectors: op, a, b, result, {V,N,C,Z}, latency.
    int         d_op  [8] = '{0, 2, 1, 9, 9, 10, 11, 10};
    int         d_a   [8] = '{'h7F, 'h10, 'h01, 'h0F, 'h10, 200, 200, 5};
    int         d_b   [8] = '{'h01, 'h20, 'h01, 'h11, 'h10, 7, 7, 0};
    int         d_res [8] = '{'h80, 'hF0, 'h03, 'hFF, 'h00, 'h1C, 'h04, 'hFF};
    logic [3:0] d_fl  [8] = '{4'b1100, 4'b0110, 4'b0000, 4'b0100, 4'b0011, 4'b0000, 4'b0000, 4'b1100};
    int         d_lat [8] = '{1, 1, 1, 9, 9, 9, 9, 1};

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic logic ovf(input int s);
        return (s > 127) || (s < -128);
    endfunction

    // Reference: plain integer arithmetic on 8-bit unsigned operands.
    function automatic void model(input int op, input int a, input int b, input logic [3:0] fin,
                                  output int res, output logic [3:0] fout);
        int   s;
        int   ci;
        logic c;
        logic v;
        c    = 1'b0;
        v    = 1'b0;
        res  = 0;
        fout = fin;
        ci   = fin[1] ? 1 : 0;
        case (op)
            0: begin s = a + b; res = s % 256; c = (s > 255); v = ovf(sgn(a) + sgn(b)); end
            1: begin s = a + b + ci; res = s % 256; c = (s > 255); v = ovf(sgn(a) + sgn(b) + ci); end
            2: begin res = (a - b + 256) % 256; c = (a < b); v = ovf(sgn(a) - sgn(b)); end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: res = 255 - a;
            7: begin res = (a * 2) % 256; c = (a >= 128); end
            8: begin res = a / 2; c = (a % 2 == 1); end
            9: begin s = a * b; res = s % 256; c = (s >= 256); end
            10, 11: begin
                if (b == 0) begin res = 255; v = 1'b1; end
                else res = (op == 10) ? a / b : a % b;
            end
            12: res = b;
            default: return;
        endcase
        fout = {v, (res >= 128), c, (res == 0)};
    endfunction

    function automatic int exp_lat(input int op, input int b);
        return (op == 9 || ((op == 10 || op == 11) && b != 0)) ? W + 1 : 1;
    endfunction

    function automatic int pick_operand();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 'hFF;
            2: return 'h7F;
            3: return 'h80;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // Present one op, clock it in, then scramble the now-ignored inputs.
    task automatic issue(input int op, input int a, input int b, input int dest);
        bus.in_valid  = 1'b1;
        bus.op        = 4'(op);
        bus.operand_a = W'(a);
        bus.operand_b = W'(b);
        bus.dest_sel  = DW'(dest);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.op        = 4'($urandom_range(0, 15));
        bus.operand_a = W'($urandom);
        bus.operand_b = W'($urandom);
        bus.dest_sel  = DW'($urandom);
    endtask

    // Count cycles from accept until out_valid, optionally driving junk ops meanwhile.
    task automatic wait_valid(input bit noise, output int lat, output int rdy_seen);
        lat      = 1;
        rdy_seen = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) rdy_seen++;
            if (noise) begin
                bus.in_valid  = 1'b1;
                bus.op        = 4'($urandom_range(0, 15));
                bus.operand_a = W'($urandom);
                bus.operand_b = W'($urandom);
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_vec++; if (bus.result !== '0) begin n_err++; $display("FAIL reset_result: got %h expected 00", bus.result); end
        n_vec++; if (bus.flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b expected 0000", bus.flags); end
        n_vec++; if (bus.out_dest !== '0) begin n_err++; $display("FAIL reset_out_dest: got %h expected 0", bus.out_dest); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        rst_n = 1'b1;
        mflags = 4'b0000;
        @(posedge clk); #1;
        n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release: got valid=%b ready=%b expected 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_directed();
        int lat;
        int rdy;
        for (int i = 0; i < 8; i++) begin
            issue(d_op[i], d_a[i], d_b[i], i);
            wait_valid(1'b0, lat, rdy);
            n_vec++; if (lat != d_lat[i]) begin n_err++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, d_lat[i]); end
            n_vec++; if (bus.result !== W'(d_res[i])) begin n_err++; $display("FAIL dir%0d_result: got %h expected %h", i, bus.result, W'(d_res[i])); end
            n_vec++; if (bus.flags !== d_fl[i]) begin n_err++; $display("FAIL dir%0d_flags: got %b expected %b", i, bus.flags, d_fl[i]); end
            n_vec++; if (bus.out_dest !== DW'(i)) begin n_err++; $display("FAIL dir%0d_dest: got %0d expected %0d", i, bus.out_dest, i); end
            if (d_lat[i] > 1) begin
                n_vec++; if (rdy != 0) begin n_err++; $display("FAIL dir%0d_in_ready_calc: got %0d ready cycles expected 0", i, rdy); end
            end
            mflags = d_fl[i];
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_cycle();
        int op, a, b, d, lat, rdy, res;
        logic [3:0] fl;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 12);
            if (op >= 9 && op <= 11) op = 13 + $urandom_range(0, 2);
            a = pick_operand();
            b = pick_operand();
            d = $urandom_range(0, 7);
            model(op, a, b, mflags, res, fl);
            issue(op, a, b, d);
            wait_valid(1'b0, lat, rdy);
            n_vec++; if (lat != 1) begin n_err++; $display("FAIL sc_latency op%0d: got %0d expected 1", op, lat); end
            n_vec++; if (bus.result !== W'(res)) begin n_err++; $display("FAIL sc_result op%0d a=%h b=%h: got %h expected %h", op, a, b, bus.result, W'(res)); end
            n_vec++; if (bus.flags !== fl) begin n_err++; $display("FAIL sc_flags op%0d a=%h b=%h: got %b expected %b", op, a, b, bus.flags, fl); end
            n_vec++; if (bus.out_dest !== DW'(d)) begin n_err++; $display("FAIL sc_dest: got %0d expected %0d", bus.out_dest, d); end
            mflags = fl;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_iterative();
        int op, a, b, d, lat, rdy, res;
        logic [3:0] fl;
        for (int i = 0; i < 30; i++) begin
            op = 9 + $urandom_range(0, 2);
            a  = pick_operand();
            b  = ($urandom_range(0, 5) == 0) ? 0 : pick_operand();
            d  = $urandom_range(0, 7);
            model(op, a, b, mflags, res, fl);
            issue(op, a, b, d);
            wait_valid(1'b1, lat, rdy);
            n_vec++; if (lat != exp_lat(op, b)) begin n_err++; $display("FAIL it_latency op%0d b=%h: got %0d expected %0d", op, b, lat, exp_lat(op, b)); end
            n_vec++; if (rdy != 0) begin n_err++; $display("FAIL it_in_ready: got %0d ready cycles expected 0", rdy); end
            n_vec++; if (bus.result !== W'(res)) begin n_err++; $display("FAIL it_result op%0d a=%h b=%h: got %h expected %h", op, a, b, bus.result, W'(res)); end
            n_vec++; if (bus.flags !== fl) begin n_err++; $display("FAIL it_flags op%0d a=%h b=%h: got %b expected %b", op, a, b, bus.flags, fl); end
            n_vec++; if (bus.out_dest !== DW'(d)) begin n_err++; $display("FAIL it_dest: got %0d expected %0d", bus.out_dest, d); end
            mflags = fl;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int op, a, b, d, lat, rdy, res, res2;
        logic [3:0] fl, fl2;
        for (int r = 0; r < 3; r++) begin
            op = (r == 1) ? 9 : $urandom_range(0, 8);
            a  = pick_operand();
            b  = pick_operand();
            d  = $urandom_range(0, 7);
            model(op, a, b, mflags, res, fl);
            bus.out_ready = 1'b0;
            issue(op, a, b, d);
            wait_valid(1'b0, lat, rdy);
            for (int k = 0; k < 5; k++) begin
                n_vec++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                    n_err++; $display("FAIL bp_hold_handshake cyc%0d: got valid=%b ready=%b expected 1/0", k, bus.out_valid, bus.in_ready);
                end
                n_vec++; if (bus.result !== W'(res) || bus.flags !== fl || bus.out_dest !== DW'(d)) begin
                    n_err++; $display("FAIL bp_hold_data cyc%0d: got %h/%b/%0d expected %h/%b/%0d", k, bus.result, bus.flags, bus.out_dest, W'(res), fl, d);
                end
                bus.in_valid  = 1'b1;
                bus.op        = 4'($urandom_range(0, 12));
                bus.operand_a = W'($urandom);
                @(posedge clk); #1;
                bus.in_valid  = 1'b0;
            end
            mflags = fl;
            op = $urandom_range(0, 8);
            a  = pick_operand();
            b  = pick_operand();
            d  = $urandom_range(0, 7);
            model(op, a, b, mflags, res2, fl2);
            bus.out_ready = 1'b1;
            issue(op, a, b, d);
            n_vec++; if (bus.out_valid !== 1'b1 || bus.result !== W'(res2) || bus.flags !== fl2 || bus.out_dest !== DW'(d)) begin
                n_err++; $display("FAIL bp_release_accept op%0d: got v=%b %h/%b/%0d expected v=1 %h/%b/%0d",
                                  op, bus.out_valid, bus.result, bus.flags, bus.out_dest, W'(res2), fl2, d);
            end
            mflags = fl2;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int op, a, b, d, lat, rdy, res;
        logic [3:0] fl;
        op = $urandom_range(0, 15); a = pick_operand(); b = pick_operand(); d = $urandom_range(0, 7);
        issue(op, a, b, d);
        for (int i = 0; i < 16; i++) begin
            model(op, a, b, mflags, res, fl);
            wait_valid(1'b0, lat, rdy);
            n_vec++; if (lat != exp_lat(op, b)) begin n_err++; $display("FAIL b2b%0d_latency op%0d: got %0d expected %0d", i, op, lat, exp_lat(op, b)); end
            n_vec++; if (bus.result !== W'(res) || bus.flags !== fl || bus.out_dest !== DW'(d)) begin
                n_err++; $display("FAIL b2b%0d_data op%0d a=%h b=%h: got %h/%b/%0d expected %h/%b/%0d",
                                  i, op, a, b, bus.result, bus.flags, bus.out_dest, W'(res), fl, d);
            end
            mflags = fl;
            if (i < 15) begin
                n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b%0d_in_ready: got %b expected 1", i, bus.in_ready); end
                op = $urandom_range(0, 15); a = pick_operand(); b = pick_operand(); d = $urandom_range(0, 7);
                issue(op, a, b, d);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc();
        int lat, rdy, nv, a, b, res;
        logic [3:0] fl;
        issue(12, 'hA5, 'hA5, 5);
        wait_valid(1'b0, lat, rdy);
        @(posedge clk); #1;
        issue(9, 'h37, 'h5B, 6);
        repeat (3) begin @(posedge clk); #1; end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rst_calc_busy: got %b expected 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL rst_calc_ctrl: got ready=%b valid=%b busy=%b expected 1/0/0", bus.in_ready, bus.out_valid, bus.busy);
        end
        n_vec++; if (bus.result !== '0 || bus.flags !== 4'b0000 || bus.out_dest !== '0) begin
            n_err++; $display("FAIL rst_calc_data: got %h/%b/%0d expected 00/0000/0", bus.result, bus.flags, bus.out_dest);
        end
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mflags = 4'b0000;
        nv = 0;
        repeat (12) begin
            if (bus.out_valid) nv++;
            @(posedge clk); #1;
        end
        n_vec++; if (nv != 0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_calc_no_result: got %0d valid cycles ready=%b expected 0 and 1", nv, bus.in_ready);
        end
        a = pick_operand(); b = pick_operand();
        model(1, a, b, mflags, res, fl);
        issue(1, a, b, 3);
        n_vec++; if (bus.out_valid !== 1'b1 || bus.result !== W'(res) || bus.flags !== fl) begin
            n_err++; $display("FAIL rst_calc_recover: got v=%b %h/%b expected v=1 %h/%b", bus.out_valid, bus.result, bus.flags, W'(res), fl);
        end
        mflags = fl;
        @(posedge clk); #1;
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        mflags        = 4'b0000;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 4'd0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.dest_sel  = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_single_cycle();
        test_iterative();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
